// File: rtl/olivia_trace_buffer_if.sv
// Capture/readout bundle for the Olivia retire-trace buffer.
// slave = the trace buffer, master = the core-side driver and trace consumer.
interface olivia_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int DATA_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              cap_valid;
  logic [PC_W-1:0]   cap_pc;
  logic [31:0]       cap_instr;
  logic [DATA_W-1:0] cap_result;
  logic              cap_mismatch;
  logic              arm;
  logic              mode;
  logic              trig_en;
  logic              trig_on_err;
  logic [PC_W-1:0]   trig_pc;
  logic              rd_ready;

  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [31:0]       rd_instr;
  logic [DATA_W-1:0] rd_result;
  logic              rd_last;
  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic              triggered;
  logic              overflow;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_result, cap_mismatch,
    output arm, mode, trig_en, trig_on_err, trig_pc, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_result, rd_last,
    input  state, count, triggered, overflow
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_result, cap_mismatch,
    input  arm, mode, trig_en, trig_on_err, trig_pc, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_result, rd_last,
    output state, count, triggered, overflow
  );
endinterface

// File: rtl/olivia_trace_buffer.sv
// Retire-trace capture buffer for the Olivia core.
// Records {PC, instruction, ALU result} into a DEPTH-entry circular buffer,
// stops on trigger (WRAP: after POST_TRIG more records; FILL: immediately or
// when full) and streams the frozen contents out oldest-first.
module olivia_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 64,
  parameter int DATA_W    = 64,
  parameter int POST_TRIG = 8
) (
  input logic               clk,
  input logic               rst,
  olivia_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            trig_q;
  logic            ovf_q;
  logic [PW-1:0]   post_q;

  logic [PC_W-1:0]   mem_pc     [DEPTH];
  logic [31:0]       mem_instr  [DEPTH];
  logic [DATA_W-1:0] mem_result [DEPTH];

  logic capturing;
  logic trig_hit;
  logic full;
  logic rd_valid_w;

  // Capture only while armed or in post-trigger; a simultaneous arm discards the record.
  assign capturing  = !bus.arm && bus.cap_valid &&
                      ((state_q == S_ARMED) || (state_q == S_POST));
  assign trig_hit   = bus.cap_valid &&
                      ((bus.trig_en && (bus.cap_pc == bus.trig_pc)) ||
                       (bus.trig_on_err && bus.cap_mismatch));
  assign full       = (count_q == CW'(DEPTH));
  assign rd_valid_w = (state_q == S_DONE) && (count_q != '0);

  // Record storage: data only, no reset needed since reads are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (capturing) begin
      mem_pc[wr_ptr_q]     <= bus.cap_pc;
      mem_instr[wr_ptr_q]  <= bus.cap_instr;
      mem_result[wr_ptr_q] <= bus.cap_result;
    end
  end

  // Capture/trigger/readout FSM with pointer, occupancy and flag bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      post_q   <= '0;
    end else if (bus.arm) begin
      state_q  <= S_ARMED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      post_q   <= '0;
    end else begin
      // A full buffer keeps its size: the oldest record is dropped instead.
      if (capturing) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (!full) begin
          count_q <= count_q + 1'b1;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          ovf_q    <= 1'b1;
        end
      end
      case (state_q)
        S_ARMED: begin
          if (bus.cap_valid) begin
            if (bus.mode) begin
              // FILL: stop on trigger or once the capture fills the buffer.
              if (trig_hit) trig_q <= 1'b1;
              if (trig_hit || full || (count_q == CW'(DEPTH - 1))) state_q <= S_DONE;
            end else if (trig_hit) begin
              trig_q <= 1'b1;
              if (POST_TRIG == 0) begin
                state_q <= S_DONE;
              end else begin
                state_q <= S_POST;
                post_q  <= PW'(POST_TRIG);
              end
            end
          end
        end
        S_POST: begin
          if (bus.cap_valid) begin
            post_q <= post_q - 1'b1;
            if (post_q == PW'(1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (rd_valid_w && bus.rd_ready) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
            if (count_q == CW'(1)) state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_valid  = rd_valid_w;
  assign bus.rd_pc     = rd_valid_w ? mem_pc[rd_ptr_q]     : '0;
  assign bus.rd_instr  = rd_valid_w ? mem_instr[rd_ptr_q]  : '0;
  assign bus.rd_result = rd_valid_w ? mem_result[rd_ptr_q] : '0;
  assign bus.rd_last   = rd_valid_w && (count_q == CW'(1));
  assign bus.state     = state_q;
  assign bus.count     = count_q;
  assign bus.triggered = trig_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_olivia_trace_buffer.sv
// Bench for olivia_trace_buffer: two DEPTH=4 instances (POST_TRIG=2 and 0)
// share one stimulus stream and are compared every cycle against a
// queue-based reference model, with directed scenarios pinned by literals.
module tb_olivia_trace_buffer;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cap_valid = 0;
  logic [63:0] cap_pc = 0;
  logic [31:0] cap_instr = 0;
  logic [63:0] cap_result = 0;
  logic        cap_mismatch = 0;
  logic        arm = 0;
  logic        mode = 0;
  logic        trig_en = 0;
  logic        trig_on_err = 0;
  logic [63:0] trig_pc = 0;
  logic        rd_ready = 0;

  olivia_trace_buffer_if #(.DEPTH(D), .PC_W(64), .DATA_W(64)) if0 ();
  olivia_trace_buffer_if #(.DEPTH(D), .PC_W(64), .DATA_W(64)) if1 ();

  assign if0.cap_valid = cap_valid;     assign if1.cap_valid = cap_valid;
  assign if0.cap_pc = cap_pc;           assign if1.cap_pc = cap_pc;
  assign if0.cap_instr = cap_instr;     assign if1.cap_instr = cap_instr;
  assign if0.cap_result = cap_result;   assign if1.cap_result = cap_result;
  assign if0.cap_mismatch = cap_mismatch; assign if1.cap_mismatch = cap_mismatch;
  assign if0.arm = arm;                 assign if1.arm = arm;
  assign if0.mode = mode;               assign if1.mode = mode;
  assign if0.trig_en = trig_en;         assign if1.trig_en = trig_en;
  assign if0.trig_on_err = trig_on_err; assign if1.trig_on_err = trig_on_err;
  assign if0.trig_pc = trig_pc;         assign if1.trig_pc = trig_pc;
  assign if0.rd_ready = rd_ready;       assign if1.rd_ready = rd_ready;

  olivia_trace_buffer #(.DEPTH(D), .PC_W(64), .DATA_W(64), .POST_TRIG(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  olivia_trace_buffer #(.DEPTH(D), .PC_W(64), .DATA_W(64), .POST_TRIG(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: buffer as an oldest-first queue ----------------
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] res;
  } rec_t;

  rec_t mq [2][$];
  int   mst [2] = '{0, 0};
  bit   mtrig [2] = '{0, 0};
  bit   movf [2] = '{0, 0};
  int   mpost [2] = '{0, 0};

  function automatic int post_trig_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  rec_t mrec;
  bit   mhit;
  always @(posedge clk or posedge rst) begin
    mhit = cap_valid && ((trig_en && cap_pc == trig_pc) || (trig_on_err && cap_mismatch));
    mrec = '{pc: cap_pc, instr: cap_instr, res: cap_result};
    for (int i = 0; i < 2; i++) begin
      if (rst || arm) begin
        mq[i].delete();
        mst[i] = rst ? 0 : 1;
        mtrig[i] = 0;
        movf[i] = 0;
        mpost[i] = 0;
      end else if ((mst[i] == 1 || mst[i] == 2) && cap_valid) begin
        mq[i].push_back(mrec);
        if (mq[i].size() > D) begin
          void'(mq[i].pop_front());
          movf[i] = 1;
        end
        if (mst[i] == 1) begin
          if (mode) begin
            if (mhit) mtrig[i] = 1;
            if (mhit || mq[i].size() == D) mst[i] = 3;
          end else if (mhit) begin
            mtrig[i] = 1;
            if (post_trig_of(i) == 0) mst[i] = 3;
            else begin
              mst[i] = 2;
              mpost[i] = post_trig_of(i);
            end
          end
        end else begin
          mpost[i]--;
          if (mpost[i] == 0) mst[i] = 3;
        end
      end else if (mst[i] == 3 && mq[i].size() > 0 && rd_ready) begin
        void'(mq[i].pop_front());
        if (mq[i].size() == 0) mst[i] = 0;
      end
    end
  end

  task automatic cmp_inst(input int i, input logic [1:0] st, input logic [2:0] cnt,
                          input logic tr, input logic ov, input logic rv, input logic rl,
                          input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] res);
    int sz;
    bit ev;
    sz = mq[i].size();
    ev = (mst[i] == 3) && (sz > 0);
    check($sformatf("i%0d state", i), 64'(st), 64'(mst[i]));
    check($sformatf("i%0d count", i), 64'(cnt), 64'(sz));
    check($sformatf("i%0d triggered", i), 64'(tr), 64'(mtrig[i]));
    check($sformatf("i%0d overflow", i), 64'(ov), 64'(movf[i]));
    check($sformatf("i%0d rd_valid", i), 64'(rv), 64'(ev));
    check($sformatf("i%0d rd_last", i), 64'(rl), 64'(ev && sz == 1));
    if (ev) begin
      check($sformatf("i%0d rd_pc", i), pc, mq[i][0].pc);
      check($sformatf("i%0d rd_instr", i), 64'(ins), 64'(mq[i][0].instr));
      check($sformatf("i%0d rd_result", i), res, mq[i][0].res);
    end
  endtask

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    cmp_inst(0, if0.state, if0.count, if0.triggered, if0.overflow, if0.rd_valid, if0.rd_last,
             if0.rd_pc, if0.rd_instr, if0.rd_result);
    cmp_inst(1, if1.state, if1.count, if1.triggered, if1.overflow, if1.rd_valid, if1.rd_last,
             if1.rd_pc, if1.rd_instr, if1.rd_result);
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m);
    mode = m;
    arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic cap(input logic [63:0] pc, input logic mm);
    cap_valid = 1;
    cap_pc = pc;
    cap_instr = $urandom;
    cap_result = {$urandom, $urandom};
    cap_mismatch = mm;
    tick();
    cap_valid = 0;
    cap_mismatch = 0;
  endtask

  logic [63:0] exp0 [D];
  logic [63:0] exp1 [D];

  task automatic drain(input int n0, input int n1, input string tag);
    int n;
    n = (n0 > n1) ? n0 : n1;
    for (int k = 0; k < n; k++) begin
      if (k < n0) begin
        check({tag, " i0 rd_valid"}, 64'(if0.rd_valid), 64'd1);
        check({tag, " i0 rd_pc"}, if0.rd_pc, exp0[k]);
        check({tag, " i0 rd_last"}, 64'(if0.rd_last), 64'(k == n0 - 1));
      end
      if (k < n1) begin
        check({tag, " i1 rd_valid"}, 64'(if1.rd_valid), 64'd1);
        check({tag, " i1 rd_pc"}, if1.rd_pc, exp1[k]);
        check({tag, " i1 rd_last"}, 64'(if1.rd_last), 64'(k == n1 - 1));
      end
      rd_ready = 1;
      tick();
      rd_ready = 0;
    end
    if (n0 > 0) check({tag, " i0 idle"}, 64'(if0.state), 64'd0);
    if (n1 > 0) check({tag, " i1 idle"}, 64'(if1.state), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    tick();
    rst = 0;
    check("reset state", 64'(if0.state), 64'd0);
    check("reset count", 64'(if0.count), 64'd0);
    check("reset rd_valid", 64'(if0.rd_valid), 64'd0);

    // Reset while three records are held.
    do_arm(1'b0);
    cap(100, 0); cap(104, 0); cap(108, 0);
    check("t1 count before rst", 64'(if0.count), 64'd3);
    #2 rst = 1;
    #1;
    check("t1 state", 64'(if0.state), 64'd0);
    check("t1 count", 64'(if0.count), 64'd0);
    check("t1 rd_valid", 64'(if0.rd_valid), 64'd0);
    check("t1 triggered", 64'(if0.triggered), 64'd0);
    check("t1 overflow", 64'(if0.overflow), 64'd0);
    tick();
    rst = 0;

    // FILL: stops when full, later captures ignored.
    do_arm(1'b1);
    for (int p = 0; p <= 20; p += 4) begin
      cap(64'(p), 0);
      if (p == 12) begin
        check("t2 done", 64'(if0.state), 64'd3);
        check("t2 count", 64'(if0.count), 64'd4);
        check("t2 overflow", 64'(if0.overflow), 64'd0);
      end
    end
    exp0 = '{64'd0, 64'd4, 64'd8, 64'd12};
    exp1 = exp0;
    drain(4, 4, "t2");

    // WRAP with PC trigger at 40.
    trig_en = 1;
    trig_pc = 40;
    do_arm(1'b0);
    for (int p = 0; p <= 60; p += 4) begin
      cap(64'(p), 0);
      if (p == 48) check("t3 done", 64'(if0.state), 64'd3);
    end
    check("t3 count", 64'(if0.count), 64'd4);
    check("t3 triggered", 64'(if0.triggered), 64'd1);
    check("t3 overflow", 64'(if0.overflow), 64'd1);
    exp0 = '{64'd36, 64'd40, 64'd44, 64'd48};
    exp1 = '{64'd28, 64'd32, 64'd36, 64'd40};
    drain(4, 4, "t3");

    // Mismatch trigger; instance 1 stops on the trigger record itself.
    trig_en = 0;
    trig_on_err = 1;
    do_arm(1'b0);
    cap(0, 0); cap(4, 0); cap(8, 1);
    check("t4 i1 done", 64'(if1.state), 64'd3);
    cap(12, 0); cap(16, 0);
    exp0 = '{64'd4, 64'd8, 64'd12, 64'd16};
    exp1 = '{64'd0, 64'd4, 64'd8, 64'd0};
    drain(4, 3, "t4");
    trig_on_err = 0;

    // Readout stalled by rd_ready low.
    do_arm(1'b1);
    cap(200, 0); cap(204, 0); cap(208, 0); cap(212, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5 stall rd_pc", if0.rd_pc, 64'd200);
      check("t5 stall count", 64'(if0.count), 64'd4);
    end
    exp0 = '{64'd200, 64'd204, 64'd208, 64'd212};
    exp1 = exp0;
    drain(4, 4, "t5");

    // Arm during POST with a capture on the same cycle.
    trig_en = 1;
    trig_pc = 300;
    do_arm(1'b0);
    cap(296, 0); cap(300, 0);
    check("t6 post", 64'(if0.state), 64'd2);
    arm = 1;
    cap(304, 0);
    arm = 0;
    check("t6 armed", 64'(if0.state), 64'd1);
    check("t6 count", 64'(if0.count), 64'd0);
    check("t6 triggered", 64'(if0.triggered), 64'd0);
    tick();
    check("t6 count later", 64'(if0.count), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      arm = ($urandom_range(0, 39) == 0);
      if (arm) begin
        mode = $urandom_range(0, 1);
        trig_en = $urandom_range(0, 1);
        trig_on_err = $urandom_range(0, 1);
        trig_pc = 64'(4 * $urandom_range(0, 15));
      end
      cap_valid = ($urandom_range(0, 9) < 7);
      cap_pc = 64'(4 * $urandom_range(0, 15));
      cap_instr = $urandom;
      cap_result = {$urandom, $urandom};
      cap_mismatch = ($urandom_range(0, 19) == 0);
      rd_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 0;
    arm = 0;
    cap_valid = 0;
    rd_ready = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
